serial_alu_ctrl: RTL and testbench
==================================

SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request strobe; accepted when start && ready at a rising edge.
REQ-005 SHALL have port a  input  WIDTH  operand A, sampled on acceptance.
REQ-006 SHALL have port b  input  WIDTH  operand B, sampled on acceptance.
REQ-007 SHALL have port op  input  2  00 AND, 01 OR, 10 ADD, 11 SUB (A-B); sampled on acceptance.
REQ-008 SHALL have port abort  input  1  cancels an operation in RUN.
REQ-009 SHALL have port ready  output  1  high in IDLE and DONE.
REQ-010 SHALL have port done  output  1  one-cycle pulse, high in DONE.
REQ-011 SHALL have port result  output  WIDTH  last completed result, held until the next completion.
REQ-012 SHALL have ports cout, overflow, zero  output  1 each  flags of the last completed operation.

Function
REQ-013 SHALL use states IDLE, RUN, DONE: IDLE->RUN on accept; RUN->DONE after WIDTH bit cycles; DONE->RUN on accept, else DONE->IDLE.
REQ-014 SHALL on accept latch a, b and op, clear bit index to 0, clear the work register and set carry to 1 for SUB, else 0.
REQ-015 SHALL in RUN drive one 1-bit slice with a[idx], b[idx], carry and op; each edge writes the slice result to work[idx], the slice cout to carry, and increments idx (LSB first).
REQ-016 SHALL enter DONE at the edge processing idx == WIDTH-1; done is therefore high in exactly the cycle beginning WIDTH edges after the accept edge.
REQ-017 SHALL on entry to DONE copy work to result, final carry to cout, and carry-in-to-MSB XOR carry-out-of-MSB to overflow for ADD/SUB (0 for AND/OR); zero = (result == 0).
REQ-018 SHALL for AND/OR give cout = 0 and overflow = 0; for SUB, cout = 1 means no borrow.
REQ-019 SHALL ignore start while in RUN (ready low); no queuing.
REQ-020 SHALL on abort in RUN return to IDLE at the next edge with no done pulse, leaving result and flags unchanged; abort on the final RUN cycle also wins.
REQ-021 SHALL ignore abort in IDLE and DONE; start and abort together in IDLE/DONE is a normal accept.
REQ-022 SHALL keep result/flags stable from the DONE entry until the next completed operation.

Reset
REQ-023 SHALL on reset asynchronously force state IDLE, idx 0, carry 0, work 0, result 0, cout 0, overflow 0, zero 0, done 0; ready is 1 from the first cycle after reset deassertion.
REQ-024 SHALL on reset during RUN discard the operation with no done pulse.

Structure
REQ-025 SHALL take the op encoding (op_t: OP_AND, OP_OR, OP_ADD, OP_SUB), the state enum and the WIDTH default from shared package alu_pkg.
REQ-026 SHALL instantiate exactly one alu_1bit slice as its datapath; no other arithmetic on the operands.

Verification
REQ-027 SHALL test ADD a=0x7F b=0x01 -> result 0x80, cout 0, overflow 1, zero 0, done exactly 8 edges after accept.
REQ-028 SHALL test SUB a=0x05 b=0x05 -> result 0x00, cout 1, overflow 0, zero 1.
REQ-029 SHALL test AND a=0xF0 b=0x3C -> 0x30, then OR same operands -> 0xFC, cout/overflow 0 both.
REQ-030 SHALL test ADD 0x10+0x20 -> 0x30, then start SUB 0x00-0x01 and abort on RUN cycle 4 -> no done pulse, result stays 0x30, ready returns.
REQ-031 SHALL test back-to-back: start held high during DONE -> second op accepted, done pulses spaced WIDTH+1 cycles apart.
REQ-032 SHALL test reset asserted mid-RUN (not clock-aligned) -> all outputs 0 immediately, no done, next op completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU controller.
//   WIDTH_DEFAULT : default operand/result width
//   op_t          : operation encoding carried on the 2-bit op port
//   state_t       : controller states
package alu_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_1bit.sv
// One-bit ALU slice used as the serial datapath.
//   a, b : operand bits of the current position
//   cin  : carry into this position
//   op   : operation (op_t)
//   y    : result bit
//   cout : carry out of this position (0 for logic ops)
module alu_1bit
    import alu_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  op_t  op,
    output logic y,
    output logic cout
);

    logic b_eff;

    always_comb begin
        y     = 1'b0;
        cout  = 1'b0;
        // SUB is A + ~B + 1; the +1 enters as the initial carry.
        b_eff = (op == OP_SUB) ? ~b : b;
        case (op)
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            default: begin
                y    = a ^ b_eff ^ cin;
                cout = (a & b_eff) | (a & cin) | (b_eff & cin);
            end
        endcase
    end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU controller: accepts an operation, processes one bit per
// clock LSB first through a single alu_1bit slice, then publishes the
// result and flags.
//   clk, reset      : clock, asynchronous active-high reset
//   start           : request strobe, accepted when start && ready
//   a, b, op        : operands and operation, sampled on accept
//   abort           : cancels an operation in RUN
//   ready           : high in IDLE and DONE
//   done            : one-cycle pulse in DONE
//   result          : last completed result
//   cout, overflow, zero : flags of the last completed operation
module serial_alu_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             abort,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_q, b_q, work, work_nxt;
    op_t              op_q;
    logic             carry, slice_y, slice_cout;
    logic             accept, last_bit, arith;

    assign ready    = (state != RUN);
    assign done     = (state == DONE);
    assign accept   = start && ready;
    assign last_bit = (idx == LAST_IDX);
    assign arith    = (op_q == OP_ADD) || (op_q == OP_SUB);

    alu_1bit u_slice (
        .a    (a_q[idx]),
        .b    (b_q[idx]),
        .cin  (carry),
        .op   (op_q),
        .y    (slice_y),
        .cout (slice_cout)
    );

    // Work register with the current bit merged in; on the last bit this is
    // the complete result, so it can be published in the same edge.
    always_comb begin
        work_nxt      = work;
        work_nxt[idx] = slice_y;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                // Abort wins even on the final bit.
                if (abort)         state_nxt = IDLE;
                else if (last_bit) state_nxt = DONE;
            end
            DONE: state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_AND;
            idx      <= '0;
            carry    <= 1'b0;
            work     <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op_t'(op);
            idx   <= '0;
            work  <= '0;
            carry <= (op_t'(op) == OP_SUB);
        end else if (state == RUN && !abort) begin
            work  <= work_nxt;
            carry <= slice_cout;
            idx   <= idx + IDX_W'(1);
            if (last_bit) begin
                result   <= work_nxt;
                cout     <= slice_cout;
                // carry holds the carry into the MSB at this point.
                overflow <= arith ? (carry ^ slice_cout) : 1'b0;
                zero     <= (work_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
module tb_serial_alu_ctrl;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [1:0]   op = 2'b00;
    logic         ready, done, cout, overflow, zero;
    logic [W-1:0] result;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .op       (op),
        .abort    (abort),
        .ready    (ready),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned/signed views of the operands.
    function automatic void ref_model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                      output logic [W-1:0] r, output logic c, output logic v, output logic z);
        longint lim = longint'(1) << (W - 1);
        longint ux = longint'(x);
        longint uy = longint'(y);
        longint sx = (ux >= lim) ? ux - 2 * lim : ux;
        longint sy = (uy >= lim) ? uy - 2 * lim : uy;
        longint u, s;
        c = 1'b0;
        v = 1'b0;
        case (o)
            2'b00: r = x & y;
            2'b01: r = x | y;
            2'b10: begin
                u = ux + uy;
                r = u[W-1:0];
                c = (u >= 2 * lim);
                s = sx + sy;
                v = (s >= lim) || (s < -lim);
            end
            default: begin
                u = ux - uy;
                r = u[W-1:0];
                c = (ux >= uy);
                s = sx - sy;
                v = (s >= lim) || (s < -lim);
            end
        endcase
        z = (r == '0);
    endfunction

    // Called at a negedge; returns 1 time unit after the accept edge.
    task automatic go(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_timeout", {31'd0, ready}, 32'd1);
        start = 1'b1;
        a = x;
        b = y;
        op = o;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts rising edges until done is seen (bounded).
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 40);
    endtask

    task automatic expect_op(input string tag, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic [W-1:0] er, input logic ec, input logic ev, input logic ez);
        int n;
        go(o, x, y);
        wait_done(n);
        check({tag, "_latency"}, n, W);
        check({tag, "_result"}, result, er);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_ovf"}, overflow, ev);
        check({tag, "_zero"}, zero, ez);
        @(posedge clk);
        #1 check({tag, "_done_pulse"}, done, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        int n, n2;
        logic seen;
        logic [1:0] ro;
        logic [W-1:0] rx, ry, er;
        logic ec, ev, ez;

        #1;
        check("rst_result", result, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", overflow, 0);
        check("rst_zero", zero, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        @(negedge clk) reset = 1'b0;
        @(negedge clk) check("rst_ready", ready, 1);

        expect_op("add_7f_01", 2'b10, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        expect_op("sub_05_05", 2'b11, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1);
        expect_op("and_f0_3c", 2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
        expect_op("or_f0_3c",  2'b01, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0);
        expect_op("sub_00_01", 2'b11, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0);
        expect_op("sub_80_01", 2'b11, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);
        expect_op("add_ff_01", 2'b10, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
        expect_op("add_10_20", 2'b10, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0);

        // Abort on RUN cycle 4.
        go(2'b11, 8'h00, 8'h01);
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_ready", ready, 1);
        check("abort_done", done, 0);
        check("abort_result", result, 8'h30);
        check("abort_cout", cout, 0);
        check("abort_ovf", overflow, 0);
        check("abort_zero", zero, 0);
        seen = 1'b0;
        repeat (W + 2) begin
            @(posedge clk);
            #1 seen = seen | done;
        end
        check("abort_no_done", seen, 0);
        @(negedge clk);

        // Abort on the final RUN cycle.
        go(2'b10, 8'h01, 8'h01);
        repeat (W - 1) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_last_done", done, 0);
        check("abort_last_ready", ready, 1);
        check("abort_last_result", result, 8'h30);
        @(negedge clk);

        // Abort alone in IDLE is ignored; start with abort is a normal accept.
        abort = 1'b1;
        @(posedge clk);
        #1 check("idle_abort_ready", ready, 1);
        @(negedge clk);
        start = 1'b1;
        a = 8'h21;
        b = 8'h03;
        op = 2'b11;
        @(posedge clk);
        #1 begin
            start = 1'b0;
            abort = 1'b0;
        end
        check("start_abort_busy", ready, 0);
        wait_done(n);
        check("start_abort_latency", n, W);
        check("start_abort_result", result, 8'h1E);
        @(negedge clk);

        // Back-to-back: start held through RUN and DONE.
        @(negedge clk);
        start = 1'b1;
        a = 8'h11;
        b = 8'h22;
        op = 2'b10;
        @(posedge clk);
        #1 begin
            a = 8'h40;
            b = 8'h01;
            op = 2'b11;
        end
        wait_done(n);
        check("b2b_first_latency", n, W);
        check("b2b_first_result", result, 8'h33);
        wait_done(n2);
        start = 1'b0;
        check("b2b_spacing", n2, W + 1);
        check("b2b_second_result", result, 8'h3F);
        check("b2b_second_cout", cout, 1);
        check("b2b_second_ovf", overflow, 0);
        @(posedge clk);
        #1 check("b2b_idle_ready", ready, 1);
        @(negedge clk);

        // Reset mid-RUN, not aligned to a clock edge.
        go(2'b10, 8'h05, 8'h06);
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("midrst_result", result, 0);
        check("midrst_cout", cout, 0);
        check("midrst_ovf", overflow, 0);
        check("midrst_zero", zero, 0);
        check("midrst_done", done, 0);
        @(posedge clk);
        #1 check("midrst_done_held", done, 0);
        @(negedge clk) reset = 1'b0;
        @(negedge clk) check("midrst_ready", ready, 1);
        expect_op("post_rst_add", 2'b10, 8'h05, 8'h06, 8'h0B, 1'b0, 1'b0, 1'b0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = W'($urandom);
            ry = W'($urandom);
            if (i % 6 == 0) ry = rx;
            ref_model(ro, rx, ry, er, ec, ev, ez);
            expect_op("rnd", ro, rx, ry, er, ec, ev, ez);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
